uart_framebuffer: RTL and testbench

Receives pixel data as bytes from `uart_receiver` and stores it in an on-chip block-RAM framebuffer of 40×20 cells, each cell 4×4 panel pixels of RGB565. Serves the `st7735` driver's pixel requests: `x`/`y` come in, `color` goes out. It replaces the procedurally generated colour. Acknowledges completed or aborted transfers through `uart_transmitter`. One clock domain (12 MHz on the Icestick).

---
 rtl/uart_framebuffer_if.sv | 21 ++
 rtl/uart_framebuffer.sv | 152 +++++++++++++++
 tb/tb_uart_framebuffer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/uart_framebuffer_if.sv
// uart_framebuffer_if: UART byte stream, ACK/NAK transmit and pixel read signals of the framebuffer
interface uart_framebuffer_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [15:0] color;
  logic        busy;
  logic        frame_done;
  modport master (
    output rx_valid, rx_data, tx_busy, x, y,
    input  tx_start, tx_data, color, busy, frame_done
  );
  modport slave (
    input  rx_valid, rx_data, tx_busy, x, y,
    output tx_start, tx_data, color, busy, frame_done
  );
endinterface

// File: rtl/uart_framebuffer.sv
// uart_framebuffer: UART-loaded 40x20 RGB565 cell framebuffer (clk, rst, fb: rx bytes in, ACK/NAK out, x/y -> color)
module uart_framebuffer #(
  parameter int COLS       = 40,
  parameter int ROWS       = 20,
  parameter int CELL_SHIFT = 2,
  parameter int TIMEOUT    = 1_200_000
) (
  input  logic clk,
  input  logic rst,
  uart_framebuffer_if.slave fb
);
  localparam int DEPTH = COLS * ROWS;
  localparam int AW    = $clog2(DEPTH);
  localparam int TW    = $clog2(TIMEOUT);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  typedef enum logic [2:0] {IDLE, LOAD_HI, LOAD_LO, FILL_HI, FILL_LO, FILLING} state_t;
  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    hi_q, hi_d;
  logic [15:0]   fill_q, fill_d;
  logic [TW-1:0] to_q, to_d;
  logic          we_q, we_d;
  logic [AW-1:0] wa_q, wa_d;
  logic [15:0]   wd_q, wd_d;
  logic          done_q, done_d;
  logic          enq, nak, counting, expire;
  logic          txf_q, tx_start_q;
  logic [7:0]    txb_q, tx_data_q;
  logic [15:0]   mem_q [DEPTH];
  logic [15:0]   rd_q;
  logic          oor, oor_q;
  logic [AW-1:0] r_a, c_a, raddr;
  assign counting = (state_q == LOAD_HI) || (state_q == LOAD_LO) || (state_q == FILL_HI) || (state_q == FILL_LO);
  assign expire   = counting && !fb.rx_valid && (to_q == TW'(TIMEOUT - 1));
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    hi_d    = hi_q;
    fill_d  = fill_q;
    to_d    = (counting && !fb.rx_valid) ? to_q + TW'(1) : '0;
    we_d    = 1'b0;
    wa_d    = addr_q;
    wd_d    = {hi_q, fb.rx_data};
    done_d  = 1'b0;
    enq     = 1'b0;
    nak     = 1'b0;
    case (state_q)
      IDLE: if (fb.rx_valid) begin
        state_d = (fb.rx_data == 8'hA5) ? LOAD_HI : (fb.rx_data == 8'h5A) ? FILL_HI : IDLE;
        addr_d  = '0;
      end
      LOAD_HI: if (fb.rx_valid) begin
        hi_d    = fb.rx_data;
        state_d = LOAD_LO;
      end
      LOAD_LO: if (fb.rx_valid) begin
        we_d    = 1'b1;
        state_d = (addr_q == LAST) ? IDLE : LOAD_HI;
        addr_d  = addr_q + AW'(1);
        done_d  = addr_q == LAST;
        enq     = addr_q == LAST;
      end
      FILL_HI: if (fb.rx_valid) begin
        hi_d    = fb.rx_data;
        state_d = FILL_LO;
      end
      FILL_LO: if (fb.rx_valid) begin
        fill_d  = {hi_q, fb.rx_data};
        addr_d  = '0;
        state_d = FILLING;
      end
      FILLING: begin
        we_d    = 1'b1;
        wd_d    = fill_q;
        state_d = (addr_q == LAST) ? IDLE : FILLING;
        addr_d  = addr_q + AW'(1);
        done_d  = addr_q == LAST;
        enq     = addr_q == LAST;
      end
      default: state_d = IDLE;
    endcase
    if (expire) begin
      state_d = IDLE;
      enq     = 1'b1;
      nak     = 1'b1;
    end
  end
  // Writes are staged one cycle so frame_done and the ACK enqueue coincide with the RAM write
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      hi_q    <= '0;
      fill_q  <= '0;
      to_q    <= '0;
      we_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      hi_q    <= hi_d;
      fill_q  <= fill_d;
      to_q    <= to_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      done_q  <= done_d;
    end
  end
  // Single pending reply slot; a fresh enqueue overrides whatever is still waiting
  always_ff @(posedge clk) begin
    if (rst) begin
      txf_q      <= 1'b0;
      txb_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      tx_start_q <= 1'b0;
      if (txf_q && !fb.tx_busy && !tx_start_q) begin
        tx_start_q <= 1'b1;
        tx_data_q  <= txb_q;
        txf_q      <= 1'b0;
      end
      if (enq) begin
        txf_q <= 1'b1;
        txb_q <= nak ? 8'h15 : 8'h06;
      end
    end
  end
  // Row index times 40 as shift-and-add; out-of-range reads are steered to cell 0 and masked
  assign oor   = (fb.x >= 8'(COLS << CELL_SHIFT)) || (fb.y >= 7'(ROWS << CELL_SHIFT));
  assign r_a   = AW'(fb.y >> CELL_SHIFT);
  assign c_a   = AW'(fb.x >> CELL_SHIFT);
  assign raddr = oor ? '0 : (r_a << 5) + (r_a << 3) + c_a;
  always_ff @(posedge clk) begin
    if (we_q) mem_q[wa_q] <= wd_q;
  end
  always_ff @(posedge clk) begin
    rd_q <= mem_q[raddr];
  end
  always_ff @(posedge clk) begin
    if (rst) oor_q <= 1'b1;
    else     oor_q <= oor;
  end
  assign fb.color      = oor_q ? 16'h0000 : rd_q;
  assign fb.tx_start   = tx_start_q;
  assign fb.tx_data    = tx_data_q;
  assign fb.busy       = state_q != IDLE;
  assign fb.frame_done = done_q;
endmodule

// File: tb/tb_uart_framebuffer.sv
// tb_uart_framebuffer: directed checks of fill, load, bounds, timeout, back-pressure and reset
module tb_uart_framebuffer;
  localparam int TO = 300;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;
  int   tx_cnt = 0;
  int   done_cnt = 0;
  logic [7:0] last_tx = 8'h00;
  uart_framebuffer_if fb();
  uart_framebuffer #(.TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .fb(fb));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (!rst && fb.tx_start) begin
      tx_cnt  <= tx_cnt + 1;
      last_tx <= fb.tx_data;
    end
    if (!rst && fb.frame_done) done_cnt <= done_cnt + 1;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b);
    fb.rx_valid = 1'b1;
    fb.rx_data  = b;
    cyc(1);
    fb.rx_valid = 1'b0;
  endtask
  task automatic rd(input logic [7:0] px, input logic [6:0] py, output logic [15:0] c);
    fb.x = px;
    fb.y = py;
    cyc(1);
    c = fb.color;
  endtask
  task automatic wait_done(input string tag, input int target, input int budget, output int n);
    n = 0;
    while (done_cnt < target && n < budget) begin
      cyc(1);
      n++;
    end
    chk(tag, done_cnt, target);
  endtask
  task automatic wait_tx(input string tag, input int target, input int budget);
    int n = 0;
    while (tx_cnt < target && n < budget) begin
      cyc(1);
      n++;
    end
    chk(tag, tx_cnt, target);
  endtask
  initial begin
    logic [15:0] c;
    int n;
    fb.rx_valid = 1'b0;
    fb.rx_data  = 8'h00;
    fb.tx_busy  = 1'b0;
    fb.x        = 8'd0;
    fb.y        = 7'd0;
    cyc(3);
    chk("rst_tx_start", fb.tx_start, 0);
    chk("rst_tx_data", fb.tx_data, 0);
    chk("rst_color", fb.color, 0);
    chk("rst_busy", fb.busy, 0);
    chk("rst_frame_done", fb.frame_done, 0);
    rst = 1'b0;
    cyc(2);
    send(8'h33);
    chk("idle_ignore", fb.busy, 0);
    send(8'h5A); send(8'hF8); send(8'h00);
    chk("fill_busy", fb.busy, 1);
    wait_done("fill_done", 1, 900, n);
    chk("fill_latency", n <= 802, 1);
    cyc(2);
    rd(8'd0, 7'd0, c);    chk("fill_0_0", c, 16'hF800);
    rd(8'd159, 7'd79, c); chk("fill_159_79", c, 16'hF800);
    rd(8'd80, 7'd40, c);  chk("fill_80_40", c, 16'hF800);
    wait_tx("fill_ack_cnt", 1, 20);
    chk("fill_ack", last_tx, 8'h06);
    chk("fill_idle", fb.busy, 0);
    send(8'hA5);
    for (int i = 0; i < 800; i++) begin
      send(8'(i >> 8));
      send(8'(i));
    end
    wait_done("load_done", 2, 10, n);
    cyc(2);
    rd(8'd5, 7'd9, c);    chk("load_5_9", c, 16'h0051);
    rd(8'd159, 7'd79, c); chk("load_159_79", c, 16'h031F);
    rd(8'd0, 7'd0, c);    chk("load_0_0", c, 16'h0000);
    rd(8'd7, 7'd3, c);    chk("load_7_3", c, 16'h0001);
    wait_tx("load_ack_cnt", 2, 20);
    chk("load_ack", last_tx, 8'h06);
    rd(8'd160, 7'd0, c);  chk("oob_x", c, 0);
    rd(8'd0, 7'd80, c);   chk("oob_y", c, 0);
    rd(8'd255, 7'd127, c); chk("oob_xy", c, 0);
    rd(8'd159, 7'd0, c);  chk("edge_159_0", c, 16'h0027);
    send(8'hA5); send(8'h12); send(8'h34); send(8'h56);
    cyc(250);
    chk("to_still_busy", fb.busy, 1);
    wait_tx("to_nak_cnt", 3, TO);
    chk("to_nak", last_tx, 8'h15);
    chk("to_idle", fb.busy, 0);
    chk("to_no_done", done_cnt, 2);
    rd(8'd0, 7'd0, c);    chk("to_cell0", c, 16'h1234);
    rd(8'd4, 7'd0, c);    chk("to_cell1", c, 16'h0001);
    fb.tx_busy = 1'b1;
    send(8'h5A); send(8'h00); send(8'h1F);
    wait_done("bp_done", 3, 900, n);
    cyc(20);
    chk("bp_held", tx_cnt, 3);
    fb.tx_busy = 1'b0;
    cyc(10);
    chk("bp_one_start", tx_cnt, 4);
    chk("bp_ack", last_tx, 8'h06);
    rd(8'd100, 7'd50, c); chk("bp_fill", c, 16'h001F);
    send(8'hA5); send(8'hAB); send(8'hCD); send(8'h11);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("mid_rst_idle", fb.busy, 0);
    cyc(TO + 20);
    chk("mid_rst_no_nak", tx_cnt, 4);
    chk("mid_rst_busy", fb.busy, 0);
    rd(8'd0, 7'd0, c);    chk("mid_rst_cell0", c, 16'hABCD);
    rd(8'd4, 7'd0, c);    chk("mid_rst_cell1", c, 16'h001F);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
